// File: rtl/core_pkg.sv
// core_pkg
// Shared definitions for the MEM stage: datapath width, load/store type
// encodings, the memory-port FSM state type and small access-size helpers.
// No ports.
package core_pkg;

  localparam int XLEN = 32;

  // Load types as produced by the decoder
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  // Store types; also used as the generic access-size code (byte/half/word)
  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // Access size of a load, expressed in the store-type encoding so loads and
  // stores share one byte-enable and alignment rule.
  function automatic logic [1:0] load_size(input logic [2:0] load_type);
    logic [1:0] size;
    case (load_type)
      LD_LB, LD_LBU: size = ST_SB;
      LD_LH, LD_LHU: size = ST_SH;
      default:       size = ST_SW;
    endcase
    return size;
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always fine.
  // Unused size code 2'b11 is treated as a word.
  function automatic logic access_misaligned(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
    logic mis;
    case (size)
      ST_SB:   mis = 1'b0;
      ST_SH:   mis = addr_lo[0];
      default: mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// load_store_align
// Purely combinational lane steering for the data-memory port.
//   Store path: addr_lo, size, wdata_in -> be, wdata_out (replicated lanes)
//   Load path : addr_lo, load_type, rdata -> load_data (extended word)
// Ports:
//   addr_lo    in  2    : byte offset within the word
//   size       in  2    : access size in store-type encoding (SB/SH/SW)
//   wdata_in   in  XLEN : raw store data (rs2)
//   load_type  in  3    : LB/LH/LW/LBU/LHU
//   rdata      in  XLEN : word returned by memory
//   be         out 4    : byte enables
//   wdata_out  out XLEN : lane-aligned store data
//   load_data  out XLEN : selected and extended load result
module load_store_align
  import core_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic [XLEN-1:0] wdata_in,
  input  logic [2:0]      load_type,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_out,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be        = 4'b1111;
    wdata_out = wdata_in;
    case (size)
      ST_SB: begin
        be        = 4'b0001 << addr_lo;
        wdata_out = {4{wdata_in[7:0]}};
      end
      ST_SH: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_out = {2{wdata_in[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_out = wdata_in;
      end
    endcase
  end

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
  end

  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = rdata;
    case (load_type)
      LD_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LD_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      LD_LBU:  load_data = {24'h000000, byte_sel};
      LD_LHU:  load_data = {16'h0000, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
// Pipeline MEM stage: EX/MEM register, ready/valid data-memory port with byte
// enables, load/store alignment, memory stall generation and MEM/WB register.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   RUN   | no outstanding request; a new op is offered straight from EX/MEM
//   WAIT  | request offered but not accepted; EX/MEM frozen, port held stable
//
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   ex_valid .. memtoreg_ex_out: execute-stage outputs captured into EX/MEM
//   dmem_req/we/addr/wdata/be  : data-memory request
//   dmem_ready, dmem_rdata     : acceptance and same-cycle read data
//   stall_mem                  : freeze upstream stages
//   data_forward_mem           : EX/MEM ALU result for forwarding
//   rd_mem, wb_reg_file_mem    : EX/MEM copies for the hazard unit
//   misaligned_mem             : misaligned access indication
//   wb_valid/data/rd/en        : MEM/WB register outputs
module mem_access_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] alu_result_ex,
  input  logic [XLEN-1:0] rs2_data_for_mem_ex,
  input  logic [4:0]      rd_ex_out,
  input  logic            mem_write_ex_out,
  input  logic            mem_read_ex_out,
  input  logic [2:0]      mem_load_type_ex_out,
  input  logic [1:0]      mem_store_type_ex_out,
  input  logic            wb_reg_file_ex_out,
  input  logic            memtoreg_ex_out,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall_mem,
  output logic [XLEN-1:0] data_forward_mem,
  output logic [4:0]      rd_mem,
  output logic            wb_reg_file_mem,
  output logic            misaligned_mem,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_en
);

  import core_pkg::*;

  // EX/MEM register
  logic            exm_valid_q;
  logic [XLEN-1:0] exm_alu_q;
  logic [XLEN-1:0] exm_rs2_q;
  logic [4:0]      exm_rd_q;
  logic            exm_mem_write_q;
  logic            exm_mem_read_q;
  logic [2:0]      exm_load_type_q;
  logic [1:0]      exm_store_type_q;
  logic            exm_wb_reg_file_q;
  logic            exm_memtoreg_q;

  // MEM/WB register
  logic            wb_valid_q, wb_valid_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [4:0]      wb_rd_q;
  logic            wb_en_q, wb_en_d;

  mem_state_e      state_q;

  logic            mem_op;
  logic            misaligned;
  logic            issue;
  logic [1:0]      access_size;
  logic [3:0]      be_aligned;
  logic [XLEN-1:0] wdata_aligned;
  logic [XLEN-1:0] load_data;

  // Bubbles clear the controls that have side effects; the data fields are
  // still captured since nothing downstream qualifies them without valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      exm_valid_q       <= 1'b0;
      exm_alu_q         <= '0;
      exm_rs2_q         <= '0;
      exm_rd_q          <= '0;
      exm_mem_write_q   <= 1'b0;
      exm_mem_read_q    <= 1'b0;
      exm_load_type_q   <= '0;
      exm_store_type_q  <= '0;
      exm_wb_reg_file_q <= 1'b0;
      exm_memtoreg_q    <= 1'b0;
    end else if (!stall_mem) begin
      exm_valid_q       <= ex_valid;
      exm_alu_q         <= alu_result_ex;
      exm_rs2_q         <= rs2_data_for_mem_ex;
      exm_rd_q          <= rd_ex_out;
      exm_mem_write_q   <= ex_valid & mem_write_ex_out;
      exm_mem_read_q    <= ex_valid & mem_read_ex_out;
      exm_load_type_q   <= mem_load_type_ex_out;
      exm_store_type_q  <= mem_store_type_ex_out;
      exm_wb_reg_file_q <= ex_valid & wb_reg_file_ex_out;
      exm_memtoreg_q    <= memtoreg_ex_out;
    end
  end

  // Stores take their size from the store type, loads from the load type.
  assign access_size = exm_mem_write_q ? exm_store_type_q : load_size(exm_load_type_q);
  assign mem_op      = exm_valid_q & (exm_mem_write_q | exm_mem_read_q);
  assign misaligned  = access_misaligned(access_size, exm_alu_q[1:0]);
  assign issue       = mem_op & ~misaligned;

  load_store_align u_align (
    .addr_lo   (exm_alu_q[1:0]),
    .size      (access_size),
    .wdata_in  (exm_rs2_q),
    .load_type (exm_load_type_q),
    .rdata     (dmem_rdata),
    .be        (be_aligned),
    .wdata_out (wdata_aligned),
    .load_data (load_data)
  );

  // In WAIT the EX/MEM register is frozen, so every request field is
  // naturally stable until dmem_ready is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (dmem_req && !dmem_ready) state_q <= WAIT;
        WAIT:    if (dmem_ready) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign dmem_req   = issue | (state_q == WAIT);
  assign dmem_we    = dmem_req & exm_mem_write_q;
  assign dmem_addr  = {exm_alu_q[XLEN-1:2], 2'b00};
  assign dmem_be    = dmem_req ? be_aligned : 4'b0000;
  assign dmem_wdata = wdata_aligned;
  assign stall_mem  = dmem_req & ~dmem_ready;

  assign misaligned_mem   = mem_op & misaligned;
  assign data_forward_mem = exm_alu_q;
  assign rd_mem           = exm_rd_q;
  assign wb_reg_file_mem  = exm_wb_reg_file_q;

  // A misaligned op retires as a bubble; stores retire valid but never write.
  always_comb begin
    wb_valid_d = exm_valid_q & ~misaligned_mem;
    wb_en_d    = wb_valid_d & exm_wb_reg_file_q & ~exm_mem_write_q;
    wb_data_d  = (exm_mem_read_q & exm_memtoreg_q) ? load_data : exm_alu_q;
  end

  // While stalled the op has not completed, so WB sees a bubble and keeps its
  // last data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_en_q    <= 1'b0;
    end else if (stall_mem) begin
      wb_valid_q <= 1'b0;
      wb_en_q    <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= exm_rd_q;
      wb_en_q    <= wb_en_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_rd    = wb_rd_q;
  assign wb_en    = wb_en_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] alu_result_ex;
  logic [31:0] rs2_data_for_mem_ex;
  logic [4:0]  rd_ex_out;
  logic        mem_write_ex_out;
  logic        mem_read_ex_out;
  logic [2:0]  mem_load_type_ex_out;
  logic [1:0]  mem_store_type_ex_out;
  logic        wb_reg_file_ex_out;
  logic        memtoreg_ex_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata = 32'h0;
  logic        stall_mem;
  logic [31:0] data_forward_mem;
  logic [4:0]  rd_mem;
  logic        wb_reg_file_mem;
  logic        misaligned_mem;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_en;

  always #5 clk = ~clk;

  mem_access_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid),
    .alu_result_ex(alu_result_ex), .rs2_data_for_mem_ex(rs2_data_for_mem_ex),
    .rd_ex_out(rd_ex_out), .mem_write_ex_out(mem_write_ex_out),
    .mem_read_ex_out(mem_read_ex_out), .mem_load_type_ex_out(mem_load_type_ex_out),
    .mem_store_type_ex_out(mem_store_type_ex_out),
    .wb_reg_file_ex_out(wb_reg_file_ex_out), .memtoreg_ex_out(memtoreg_ex_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .stall_mem(stall_mem),
    .data_forward_mem(data_forward_mem), .rd_mem(rd_mem),
    .wb_reg_file_mem(wb_reg_file_mem), .misaligned_mem(misaligned_mem),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_en(wb_en)
  );

  typedef struct {
    bit          v;
    bit          ld;
    bit          st;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [2:0]  lt;
    logic [1:0]  stt;
    bit          wbrf;
    bit          m2r;
  } ins_t;

  // Expected behaviour of whatever instruction currently sits in EX/MEM
  typedef struct {
    bit          valid;
    bit          req;
    bit          mis;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    bit          wbrf;
    bit          wb_en;
    logic [31:0] wb_data;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    bit          en;
  } wb_t;

  wb_t         wbq[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  int          ready_pct = 100;
  int          forced_wait = 0;
  bit          last_stall = 0;
  bit          mon_en = 0;
  int          stall_seen = 0;
  int          mis_seen = 0;
  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Memory model: read data follows the presented word address
  always @(posedge clk) begin
    #2;
    dmem_rdata = mem_rd(dmem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: byte count and offset decide everything, straight from the rules
  function automatic exp_t model(input ins_t i);
    exp_t        e;
    int          size;
    logic [1:0]  a;
    logic [31:0] lane;
    logic [31:0] ldv;
    e = '{default: 0};
    e.valid = i.v;
    e.alu   = i.alu;
    e.rd    = i.rd;
    e.wbrf  = i.v & i.wbrf;
    if (!i.v) return e;
    a = i.alu[1:0];
    if (i.st) size = (i.stt == 2'b00) ? 1 : (i.stt == 2'b01) ? 2 : 4;
    else      size = (i.lt == 3'b000 || i.lt == 3'b100) ? 1 :
                     (i.lt == 3'b001 || i.lt == 3'b101) ? 2 : 4;
    if (i.ld || i.st) e.mis = (size == 2 && a[0]) || (size == 4 && a != 2'b00);
    e.req   = (i.ld || i.st) && !e.mis;
    e.we    = i.st;
    e.addr  = {i.alu[31:2], 2'b00};
    e.be    = 4'(((1 << size) - 1) << a);
    e.wdata = (size == 1) ? {4{i.rs2[7:0]}} : (size == 2) ? {2{i.rs2[15:0]}} : i.rs2;
    lane = mem_rd(e.addr) >> (8 * a);
    case (i.lt)
      3'b000:  ldv = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ldv = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ldv = {24'h0, lane[7:0]};
      3'b101:  ldv = {16'h0, lane[15:0]};
      default: ldv = lane;
    endcase
    e.wb_data = (i.ld && i.m2r) ? ldv : i.alu;
    e.wb_en   = i.wbrf && !i.st && !e.mis;
    return e;
  endfunction

  function automatic ins_t bub();
    ins_t i;
    i = '{default: 0};
    return i;
  endfunction

  function automatic ins_t mk_alu(input logic [31:0] res, input logic [4:0] rd);
    ins_t i;
    i = bub();
    i.v = 1; i.alu = res; i.rd = rd; i.wbrf = 1;
    return i;
  endfunction

  function automatic ins_t mk_ld(input logic [31:0] a, input logic [2:0] lt, input logic [4:0] rd);
    ins_t i;
    i = bub();
    i.v = 1; i.ld = 1; i.alu = a; i.lt = lt; i.rd = rd; i.wbrf = 1; i.m2r = 1;
    return i;
  endfunction

  function automatic ins_t mk_st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] stt);
    ins_t i;
    i = bub();
    i.v = 1; i.st = 1; i.alu = a; i.rs2 = d; i.stt = stt;
    return i;
  endfunction

  function automatic ins_t mk_rand();
    ins_t       i;
    logic [2:0] lts [5];
    int         kind;
    lts = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    i = bub();
    i.v    = ($urandom_range(0, 9) != 0);
    i.alu  = $urandom;
    i.rs2  = $urandom;
    i.rd   = 5'($urandom_range(0, 31));
    i.lt   = lts[$urandom_range(0, 4)];
    i.stt  = 2'($urandom_range(0, 2));
    kind   = $urandom_range(0, 2);
    if (kind == 0) begin
      i.wbrf = 1'($urandom_range(0, 1));
    end else if (kind == 1) begin
      i.ld = 1; i.wbrf = 1; i.m2r = ($urandom_range(0, 7) != 0);
    end else begin
      i.st = 1;
    end
    return i;
  endfunction

  // One clock: drive EX + ready after the edge, decide at the negedge whether
  // the EX/MEM occupant moves on, then update the model after the next edge.
  task automatic cycle(input ins_t i, input bit do_rst);
    bit   rdy;
    exp_t nxt;
    wb_t  w;
    rst                   = do_rst;
    ex_valid              = i.v;
    alu_result_ex         = i.alu;
    rs2_data_for_mem_ex   = i.rs2;
    rd_ex_out             = i.rd;
    mem_write_ex_out      = i.st;
    mem_read_ex_out       = i.ld;
    mem_load_type_ex_out  = i.lt;
    mem_store_type_ex_out = i.stt;
    wb_reg_file_ex_out    = i.wbrf;
    memtoreg_ex_out       = i.m2r;
    if (forced_wait > 0 && cur.req) begin
      rdy = 0;
      forced_wait--;
    end else begin
      rdy = ($urandom_range(0, 99) < ready_pct);
    end
    dmem_ready = rdy;
    @(negedge clk);
    last_stall = cur.req && !rdy;
    if (!do_rst && !last_stall && cur.valid && !cur.mis) begin
      w.data = cur.wb_data; w.rd = cur.rd; w.en = cur.wb_en;
      wbq.push_back(w);
    end
    nxt = model(i);
    @(posedge clk);
    #1;
    if (do_rst) begin
      cur = '{default: 0};
      wbq.delete();
      forced_wait = 0;
    end else if (!last_stall) begin
      cur = nxt;
    end
  endtask

  task automatic send(input ins_t i);
    do cycle(i, 0); while (last_stall);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      chk("dmem_req", 32'(dmem_req), 32'(cur.req));
      chk("stall_mem", 32'(stall_mem), 32'(cur.req & ~dmem_ready));
      chk("misaligned_mem", 32'(misaligned_mem), 32'(cur.valid & cur.mis));
      chk("wb_reg_file_mem", 32'(wb_reg_file_mem), 32'(cur.wbrf));
      if (stall_mem === 1'b1) stall_seen++;
      if (misaligned_mem === 1'b1) mis_seen++;
      if (cur.req) begin
        chk("dmem_addr", dmem_addr, cur.addr);
        chk("dmem_we", 32'(dmem_we), 32'(cur.we));
        chk("dmem_be", 32'(dmem_be), 32'(cur.be));
        if (cur.we) chk("dmem_wdata", dmem_wdata, cur.wdata);
      end
      if (cur.valid) begin
        chk("data_forward_mem", data_forward_mem, cur.alu);
        chk("rd_mem", 32'(rd_mem), 32'(cur.rd));
      end
      if (wb_valid === 1'b1) begin
        if (wbq.size() == 0) begin
          chk("wb_valid_unexpected", 32'(wb_valid), 32'd0);
        end else begin
          wb_t w;
          w = wbq.pop_front();
          chk("wb_en", 32'(wb_en), 32'(w.en));
          chk("wb_rd", 32'(wb_rd), 32'(w.rd));
          if (w.en) chk("wb_data", wb_data, w.data);
        end
      end else begin
        chk("wb_en_idle", 32'(wb_en), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int s;
    int m;
    cur = '{default: 0};
    cycle(bub(), 1);
    cycle(bub(), 1);
    chk("rst_dmem_req", 32'(dmem_req), 0);
    chk("rst_dmem_we", 32'(dmem_we), 0);
    chk("rst_dmem_be", 32'(dmem_be), 0);
    chk("rst_stall_mem", 32'(stall_mem), 0);
    chk("rst_misaligned", 32'(misaligned_mem), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_en", 32'(wb_en), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", 32'(wb_rd), 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_fwd", data_forward_mem, 0);
    mon_en = 1;

    // SB at 0x103, zero-wait memory
    send(mk_st(32'h103, 32'h0000_00A5, 2'b00));
    send(bub());
    chk("sb_addr_model", cur.addr, 32'h0);
    // LH / LHU at 0x202 against a known word
    mem_ovr[32'h200] = 32'h8001_1234;
    send(mk_ld(32'h202, 3'b001, 5'd3));
    send(mk_ld(32'h202, 3'b101, 5'd4));
    send(bub());
    send(bub());

    // LW with three wait cycles
    s = stall_seen;
    send(mk_ld(32'h300, 3'b010, 5'd7));
    forced_wait = 3;
    send(bub());
    send(bub());
    chk("lw_stall_cycles", 32'(stall_seen - s), 32'd3);

    // Misaligned LW
    m = mis_seen;
    send(mk_ld(32'h006, 3'b010, 5'd8));
    send(bub());
    send(bub());
    chk("misaligned_pulses", 32'(mis_seen - m), 32'd1);

    // ADD feeding a dependent op
    send(mk_alu(32'h55, 5'd9));
    send(mk_alu(32'h56, 5'd10));
    send(bub());
    send(bub());

    // Back-to-back memory ops, ready held high: no stalls
    s = stall_seen;
    for (int k = 0; k < 8; k++) send(mk_ld(32'h400 + 32'(4 * k), 3'b010, 5'(k)));
    send(bub());
    chk("b2b_no_stall", 32'(stall_seen - s), 32'd0);

    // Randomized traffic with random ready
    ready_pct = 60;
    for (int k = 0; k < 400; k++) send(mk_rand());
    ready_pct = 100;
    send(bub());
    send(bub());

    // Reset while waiting on memory
    send(mk_ld(32'h500, 3'b010, 5'd11));
    forced_wait = 10;
    cycle(bub(), 0);
    cycle(bub(), 0);
    cycle(bub(), 1);
    chk("rstwait_dmem_req", 32'(dmem_req), 0);
    chk("rstwait_stall_mem", 32'(stall_mem), 0);
    chk("rstwait_wb_valid", 32'(wb_valid), 0);
    send(bub());
    send(mk_alu(32'hCAFE_0001, 5'd12));
    send(bub());
    send(bub());

    chk("wb_queue_drained", 32'(wbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage that consumes the execute stage's EX/MEM outputs. It holds the EX/MEM pipeline register and drives a ready/valid data-memory port with byte enables. It aligns store data, extracts and extends load data, and stalls the pipeline while memory is not ready. It returns the EX/MEM ALU result to the execute stage as `data_forward_mem` and presents registered MEM/WB outputs.

## Interface
Clocking: one clock; reset is synchronous and active-high.

Parameters:
- `XLEN`, 32: datapath width. Only 32 is supported.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `ex_valid` in 1: EX outputs this cycle form a real instruction.
- `alu_result_ex` in 32: effective address or ALU result.
- `rs2_data_for_mem_ex` in 32: forwarded store data.
- `rd_ex_out` in 5: destination register.
- `mem_write_ex_out` in 1: store.
- `mem_read_ex_out` in 1: load.
- `mem_load_type_ex_out` in 3: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- `mem_store_type_ex_out` in 2: SB=00, SH=01, SW=10.
- `wb_reg_file_ex_out` in 1: register-file write enable.
- `memtoreg_ex_out` in 1: select load data for writeback.
- `dmem_req` out 1: request valid.
- `dmem_we` out 1: write request.
- `dmem_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `dmem_wdata` out 32: lane-aligned store data.
- `dmem_be` out 4: byte enables.
- `dmem_ready` in 1: request accepted. For a read, `dmem_rdata` is valid in the same cycle.
- `dmem_rdata` in 32: read word.
- `stall_mem` out 1: freeze PC, IF/ID, ID/EX and the EX outputs.
- `data_forward_mem` out 32: EX/MEM ALU result, fed to the execute forwarding mux.
- `rd_mem`, `wb_reg_file_mem` out 5/1: EX/MEM copies used by the hazard unit.
- `misaligned_mem` out 1: one-cycle pulse for a misaligned access.
- `wb_valid` out 1: MEM/WB register valid.
- `wb_data` out 32: MEM/WB writeback data.
- `wb_rd` out 5: MEM/WB destination register.
- `wb_en` out 1: MEM/WB register-file write enable.

## Operation
- EX/MEM register
  - Captures all EX inputs on the edge when `stall_mem`=0; holds them otherwise.
  - `ex_valid`=0 captures a bubble: valid=0, with `wb_reg_file` and memory controls cleared.
- Memory op: a valid entry with read or write set.
  - A misaligned op issues no request. Misaligned means halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - The misaligned op pulses `misaligned_mem` and retires as a bubble (`wb_en`=0).
- Store alignment
  - SB: `dmem_be` = 1<<`addr[1:0]`; the byte is replicated on all four lanes.
  - SH: `dmem_be` = 0011 or 1100 by `addr[1]`; the halfword is replicated on both halves.
  - SW: `dmem_be` = 1111.
- Load extraction
  - Select the lane of `dmem_rdata` by `addr[1:0]`.
  - LB and LH sign-extend; LBU and LHU zero-extend. LW passes the word through.
  - Loads drive `dmem_be` as for stores (the `dmem_be` rule above).
- Non-memory entries pass straight to MEM/WB: `wb_data` = ALU result.
- Memory entries with `memtoreg`=1 write the extracted load data. Stores write nothing (`wb_en`=0).
- FSM states
  - RUN: `dmem_req` = valid memory op and not misaligned, driven combinationally from the EX/MEM register. If `dmem_ready`=1, the op completes this edge. If 0, go to WAIT.
  - WAIT: `dmem_req`=1, and addr, we, be and wdata are held stable. On `dmem_ready`=1 the op completes and the FSM returns to RUN.
- `stall_mem` = `dmem_req` & ~`dmem_ready`. This is combinational in both states.
- While stalled:
  - The MEM/WB register captures a bubble (`wb_valid`=0).
  - `data_forward_mem`, `rd_mem` and `wb_reg_file_mem` remain valid.

## Timing
- Latency for zero-wait memory: EX-to-EX/MEM is 1 edge and EX/MEM-to-MEM/WB is 1 edge.
- Each cycle of `dmem_ready`=0 adds exactly one stall cycle.
- Back-to-back memory ops with `dmem_ready` held high issue one request per cycle and never stall.
- Reset values:
  - EX/MEM valid=0; FSM=RUN.
  - `dmem_req`, `dmem_we`, `dmem_be`, `stall_mem`, `misaligned_mem`, `wb_valid` and `wb_en` are all 0.
  - `wb_data`, `wb_rd`, `dmem_addr`, `dmem_wdata` and `data_forward_mem` are 0.
- Reset in WAIT: the FSM returns to RUN and `dmem_req` drops at that edge. The memory must tolerate an abandoned request.
- `dmem_ready` while `dmem_req`=0 is ignored.

## Structure
- Shared package `core_pkg` holds:
  - load-type and store-type encodings;
  - FSM state enum `{RUN, WAIT}`;
  - `XLEN`.
- One sub-module `load_store_align`, purely combinational:
  - store path: addr[1:0], type, rs2 → be, wdata;
  - load path: addr[1:0], type, rdata → extended word.
- Everything else stays in `mem_access_stage`: pipeline registers, FSM and stall logic.

## Test plan
- SB at addr 0x103 with rs2=0x000000A5, ready=1 → `dmem_addr`=0x100, `dmem_be`=1000, `dmem_wdata`=0xA5A5A5A5, no stall, `wb_en`=0.
- LH at addr 0x202, rdata=0x8001_1234 → `wb_data`=0xFFFF8001. The same with LHU → 0x00008001.
- LW with ready low for 3 cycles → `stall_mem` is high for exactly 3 cycles, and the request fields are stable throughout. `wb_valid` pulses once with the data.
- LW at addr 0x006 → no `dmem_req`, one-cycle `misaligned_mem`, and `wb_en`=0.
- ADD result 0x55 followed by a dependent op → `data_forward_mem`=0x55 in the next cycle, then `wb_data`=0x55 and `wb_en`=1.
- Assert `rst` while in WAIT → the next cycle shows `dmem_req`=0, `stall_mem`=0 and `wb_valid`=0.
